// File: rtl/timing_peak_detect_pkg.sv
// Data types shared by the ML timing/CFO estimator datapath.
//   gamma_t  : signed Q7.8 correlation sum component
//   phi_t    : unsigned Q6.8 energy term
//   mag_t    : unsigned Q9.8 magnitude estimate
//   lambda_t : signed Q9.8 log-likelihood metric
package timing_peak_detect_pkg;

   localparam int GAMMA_W    = 16;
   localparam int GAMMA_FRAC = 8;
   localparam int PHI_W      = 14;
   localparam int PHI_FRAC   = 8;
   localparam int MAG_W      = GAMMA_W + 1;
   localparam int LAMBDA_W   = 18;

   typedef logic signed [GAMMA_W-1:0]  gamma_t;
   typedef logic        [PHI_W-1:0]    phi_t;
   typedef logic        [MAG_W-1:0]    mag_t;
   typedef logic signed [LAMBDA_W-1:0] lambda_t;

   // Absolute value as unsigned; the most negative input maps to 2^(W-1) exactly.
   function automatic logic [GAMMA_W-1:0] abs_gamma(input gamma_t v);
      logic [GAMMA_W-1:0] neg;
      neg = GAMMA_W'(-v);
      return v[GAMMA_W-1] ? neg : GAMMA_W'(v);
   endfunction

endpackage

// File: rtl/cplx_mag_approx.sv
// Combinational complex magnitude estimate (alpha-max beta-min, alpha=1, beta=1/2).
//   re, im : signed Q7.8 components
//   mag    : unsigned Q9.8, max(|re|,|im|) + min(|re|,|im|)/2
module cplx_mag_approx
   import timing_peak_detect_pkg::*;
(
   input  gamma_t re,
   input  gamma_t im,
   output mag_t   mag
);

   logic [GAMMA_W-1:0] a;
   logic [GAMMA_W-1:0] b;

   always_comb begin
      a = abs_gamma(re);
      b = abs_gamma(im);
      // Worst case 32768 + 16384 fits in MAG_W bits.
      if (a >= b) begin
         mag = {1'b0, a} + {2'b00, b[GAMMA_W-1:1]};
      end else begin
         mag = {1'b0, b} + {2'b00, a[GAMMA_W-1:1]};
      end
   end

endmodule

// File: rtl/timing_peak_detect.sv
// Per-window peak search of lambda = |gamma| - phi.
//   clk, rst                     : clock, asynchronous active-low reset
//   in_valid, gamma_re/im, phi_in: accepted sample
//   restart                      : aborts the current window (sample, if valid, becomes idx 0)
//   out_valid                    : one-cycle pulse at window end (after skipped windows)
//   theta_out, gamma_pk_re/im, lambda_pk : peak index, gamma and metric, held between pulses
module timing_peak_detect
   import timing_peak_detect_pkg::*;
#(
   parameter  int SYM_LEN      = 80,
   parameter  int SKIP_WINDOWS = 1,
   localparam int IDX_W        = $clog2(SYM_LEN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  gamma_t           gamma_re,
   input  gamma_t           gamma_im,
   input  phi_t             phi_in,
   input  logic             restart,
   output logic             out_valid,
   output logic [IDX_W-1:0] theta_out,
   output gamma_t           gamma_pk_re,
   output gamma_t           gamma_pk_im,
   output lambda_t          lambda_pk
);

   localparam int WIN_W = (SKIP_WINDOWS > 0) ? $clog2(SKIP_WINDOWS + 1) : 1;
   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(SYM_LEN - 1);

   mag_t    mag;
   lambda_t lambda;

   logic [IDX_W-1:0] idx_q, idx_d, cur_idx;
   logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
   lambda_t          best_lambda_q, best_lambda_d;
   logic [IDX_W-1:0] best_idx_q, best_idx_d;
   gamma_t           best_re_q, best_re_d;
   gamma_t           best_im_q, best_im_d;
   logic             take, win_end, skip_done, emit;

   cplx_mag_approx u_mag (
      .re  (gamma_re),
      .im  (gamma_im),
      .mag (mag)
   );

   // Range is exact: mag <= 49152, phi <= 16383, both fit an 18-bit signed difference.
   assign lambda = $signed({1'b0, mag}) - $signed({4'b0000, phi_in});

   always_comb begin
      // A restart sample is the first sample of the new window.
      cur_idx   = restart ? '0 : idx_q;
      take      = in_valid && ((cur_idx == '0) || (lambda > best_lambda_q));
      win_end   = in_valid && !restart && (idx_q == LastIdx);
      skip_done = int'(win_cnt_q) >= SKIP_WINDOWS;
      emit      = win_end && skip_done;

      best_lambda_d = best_lambda_q;
      best_idx_d    = best_idx_q;
      best_re_d     = best_re_q;
      best_im_d     = best_im_q;
      if (take) begin
         best_lambda_d = lambda;
         best_idx_d    = cur_idx;
         best_re_d     = gamma_re;
         best_im_d     = gamma_im;
      end

      idx_d = idx_q;
      if (restart) begin
         idx_d = in_valid ? IDX_W'(1) : '0;
      end else if (in_valid) begin
         idx_d = (idx_q == LastIdx) ? '0 : idx_q + IDX_W'(1);
      end

      win_cnt_d = win_cnt_q;
      if (win_end && !skip_done) begin
         win_cnt_d = win_cnt_q + WIN_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q         <= '0;
         win_cnt_q     <= '0;
         best_lambda_q <= '0;
         best_idx_q    <= '0;
         best_re_q     <= '0;
         best_im_q     <= '0;
         out_valid     <= 1'b0;
         theta_out     <= '0;
         gamma_pk_re   <= '0;
         gamma_pk_im   <= '0;
         lambda_pk     <= '0;
      end else begin
         idx_q         <= idx_d;
         win_cnt_q     <= win_cnt_d;
         best_lambda_q <= best_lambda_d;
         best_idx_q    <= best_idx_d;
         best_re_q     <= best_re_d;
         best_im_q     <= best_im_d;
         out_valid     <= emit;
         // Final tracker values already include the window's last sample.
         if (emit) begin
            theta_out   <= best_idx_d;
            gamma_pk_re <= best_re_d;
            gamma_pk_im <= best_im_d;
            lambda_pk   <= best_lambda_d;
         end
      end
   end

endmodule

// File: tb/tb_timing_peak_detect.sv
module tb_timing_peak_detect;

   localparam int SYM = 80;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [15:0] gamma_re;
   logic [15:0] gamma_im;
   logic [13:0] phi_in;
   logic        restart;
   logic        out_valid;
   logic [6:0]  theta_out;
   logic [15:0] gamma_pk_re;
   logic [15:0] gamma_pk_im;
   logic [17:0] lambda_pk;

   timing_peak_detect #(
      .SYM_LEN      (SYM),
      .SKIP_WINDOWS (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .gamma_re    (gamma_re),
      .gamma_im    (gamma_im),
      .phi_in      (phi_in),
      .restart     (restart),
      .out_valid   (out_valid),
      .theta_out   (theta_out),
      .gamma_pk_re (gamma_pk_re),
      .gamma_pk_im (gamma_pk_im),
      .lambda_pk   (lambda_pk)
   );

   typedef struct {
      int unsigned due;
      logic [6:0]  theta;
      logic [15:0] re;
      logic [15:0] im;
      logic [17:0] lam;
   } exp_t;

   exp_t        sb[$];
   exp_t        last;
   bit          have_last;
   int unsigned cyc;
   int          n_checks;
   int          n_fail;

   logic [15:0] a_re  [SYM];
   logic [15:0] a_im  [SYM];
   logic [13:0] a_phi [SYM];

   // Hand-computed window results.
   exp_t e_peak, e_tie, e_ext;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         have_last = 0;
      end else if (out_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_out_valid", 64'(out_valid), 64'(0));
         end else begin
            e = sb.pop_front();
            check("pulse_cycle", 64'(cyc), 64'(e.due));
            check("theta_out", 64'(theta_out), 64'(e.theta));
            check("gamma_pk_re", 64'(gamma_pk_re), 64'(e.re));
            check("gamma_pk_im", 64'(gamma_pk_im), 64'(e.im));
            check("lambda_pk", 64'(lambda_pk), 64'(e.lam));
            last      = e;
            have_last = 1;
         end
      end else if (have_last) begin
         check("hold_theta", 64'(theta_out), 64'(last.theta));
         check("hold_lambda", 64'(lambda_pk), 64'(last.lam));
         check("hold_gamma", 64'({gamma_pk_re, gamma_pk_im}), 64'({last.re, last.im}));
      end
   end

   task automatic fill(input logic [15:0] re, input logic [15:0] im, input logic [13:0] phi);
      for (int i = 0; i < SYM; i++) begin
         a_re[i]  = re;
         a_im[i]  = im;
         a_phi[i] = phi;
      end
   endtask

   task automatic load_peak();
      fill(16'h0100, 16'h0000, 14'h0000);
      a_re[37] = 16'h0800;
      a_im[37] = 16'h0400;
   endtask

   task automatic load_tie();
      fill(16'h0000, 16'h0000, 14'h3FFF);
      a_re[10] = 16'h1000; a_phi[10] = 14'h0;
      a_im[50] = 16'hF000; a_phi[50] = 14'h0;  // |-0x1000| ties idx 10
   endtask

   task automatic load_ext();
      fill(16'h0000, 16'h0000, 14'h3FFF);
      a_re[79]  = 16'h8000;
      a_im[79]  = 16'h8000;
      a_phi[79] = 14'h0100;
   endtask

   task automatic load_decoy();
      fill(16'h0100, 16'h0000, 14'h0000);
      a_re[5] = 16'h7000;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      restart  = 1'b0;
      gamma_re = 16'($urandom);
      gamma_im = 16'($urandom);
      phi_in   = 14'($urandom);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int i, input bit rs, input bit gaps, input bit push, input exp_t e);
      exp_t x;
      if (gaps) repeat ($urandom_range(0, 3)) idle();
      in_valid = 1'b1;
      restart  = rs;
      gamma_re = a_re[i];
      gamma_im = a_im[i];
      phi_in   = a_phi[i];
      if (push) begin
         x     = e;
         x.due = cyc + 1;
         sb.push_back(x);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      restart  = 1'b0;
   endtask

   task automatic play_window(input bit rs_first, input bit gaps, input bit expect_out,
                              input exp_t e);
      for (int i = 0; i < SYM; i++) begin
         send(i, rs_first && (i == 0), gaps, expect_out && (i == SYM - 1), e);
      end
   endtask

   task automatic partial(input int n);
      for (int i = 0; i < n; i++) send(i, 1'b0, 1'b0, 1'b0, e_peak);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
      check({tag, "_theta"}, 64'(theta_out), 64'(0));
      check({tag, "_gamma_pk"}, 64'({gamma_pk_re, gamma_pk_im}), 64'(0));
      check({tag, "_lambda_pk"}, 64'(lambda_pk), 64'(0));
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      have_last = 0;
      rst      = 1'b0;
      in_valid = 1'b0;
      restart  = 1'b0;
      gamma_re = '0;
      gamma_im = '0;
      phi_in   = '0;

      e_peak = '{due: 0, theta: 7'd37, re: 16'h0800, im: 16'h0400, lam: 18'h00A00};
      e_tie  = '{due: 0, theta: 7'd10, re: 16'h1000, im: 16'h0000, lam: 18'h01000};
      // mag = 32768 + 16384 = 49152; lambda = 49152 - 256 = 0xBF00
      e_ext  = '{due: 0, theta: 7'd79, re: 16'h8000, im: 16'h8000, lam: 18'h0BF00};

      #1;
      check_zero_outputs("reset");
      #21;
      rst = 1'b1;

      // First window after reset is suppressed.
      load_peak();
      play_window(1'b0, 1'b0, 1'b0, e_peak);
      play_window(1'b0, 1'b0, 1'b1, e_peak);
      load_tie();
      play_window(1'b0, 1'b0, 1'b1, e_tie);
      load_ext();
      play_window(1'b0, 1'b0, 1'b1, e_ext);
      repeat (5) idle();

      // Restart at idx 40 with a sample: decoy peak must be discarded.
      load_decoy();
      partial(40);
      load_peak();
      play_window(1'b1, 1'b0, 1'b1, e_peak);

      // Restart coinciding with window end: no pulse, sample starts the new window.
      load_decoy();
      partial(79);
      load_tie();
      play_window(1'b1, 1'b0, 1'b1, e_tie);
      repeat (3) idle();

      // Asynchronous reset at idx 20, between clock edges.
      load_peak();
      partial(20);
      #2;
      rst = 1'b0;
      #1;
      check_zero_outputs("midreset");
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;

      // Skip count restarted; three windows with random gaps, two pulses.
      load_peak();
      play_window(1'b0, 1'b1, 1'b0, e_peak);
      load_tie();
      play_window(1'b0, 1'b1, 1'b1, e_tie);
      load_ext();
      play_window(1'b0, 1'b1, 1'b1, e_ext);

      repeat (5) idle();
      check("pending_pulses", 64'(sb.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
